// File: rtl/uart_rx_param.sv
// UART receiver with selectable baud rate, 5..8 data bits, optional odd/even parity,
// 3-point majority sampling and a level-valid / ready handshake on the received byte.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  input  logic [2:0] baud_set,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int unsigned BPS_0 = CLK_FREQ / 9600;
  localparam int unsigned BPS_1 = CLK_FREQ / 19200;
  localparam int unsigned BPS_2 = CLK_FREQ / 38400;
  localparam int unsigned BPS_3 = CLK_FREQ / 57600;
  localparam int unsigned BPS_4 = CLK_FREQ / 115200;
  localparam int unsigned CNT_W = $clog2(BPS_0 + 1);
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 hist_q;
  logic [2:0]           baud_q, baud_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;

  logic                 rx_s_c;
  logic                 start_edge_c;
  logic [CNT_W-1:0]     bps_c;
  logic [CNT_W-1:0]     half_c;
  logic [CNT_W-1:0]     eighth_c;
  logic                 bit_end_c;
  logic                 smp3_hit_c;
  logic                 maj_c;
  logic                 ones_c;

  // Metastability synchronizer plus one history stage for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
      hist_q <= sync_q[1];
    end
  end

  assign rx_s_c       = sync_q[1];
  assign start_edge_c = ~rx_s_c & hist_q;

  always_comb begin
    case (baud_q)
      3'd0:    bps_c = CNT_W'(BPS_0);
      3'd1:    bps_c = CNT_W'(BPS_1);
      3'd2:    bps_c = CNT_W'(BPS_2);
      3'd3:    bps_c = CNT_W'(BPS_3);
      default: bps_c = CNT_W'(BPS_4);
    endcase
  end

  assign half_c     = bps_c >> 1;
  assign eighth_c   = bps_c >> 3;
  assign bit_end_c  = (cnt_q == bps_c - CNT_W'(1));
  assign smp3_hit_c = (cnt_q == half_c + eighth_c);
  // Third sample is taken live; the first two were captured earlier in the bit
  assign maj_c      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_c) | (samp_q[1] & rx_s_c);
  assign ones_c     = ^{shreg_q, maj_c};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      baud_q        <= 3'd0;
      cnt_q         <= '0;
      idx_q         <= '0;
      samp_q        <= 2'b00;
      shreg_q       <= '0;
      perr_q        <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      samp_q        <= samp_d;
      shreg_q       <= shreg_d;
      perr_q        <= perr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    cnt_d         = bit_end_c ? '0 : cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    samp_d        = samp_q;
    shreg_d       = shreg_q;
    perr_d        = perr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q & ~rx_ready;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;

    if (cnt_q == half_c - eighth_c) samp_d[0] = rx_s_c;
    if (cnt_q == half_c)            samp_d[1] = rx_s_c;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_edge_c) begin
          state_d = S_START;
          baud_d  = baud_set;
          idx_d   = '0;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (smp3_hit_c && maj_c) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (bit_end_c) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (smp3_hit_c) shreg_d = {maj_c, shreg_q[DATA_BITS-1:1]};
        if (bit_end_c) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (smp3_hit_c) perr_d = (PARITY == 1) ? ~ones_c : ones_c;
        if (bit_end_c)  state_d = S_STOP;
      end
      S_STOP: begin
        // Decide on the third stop sample so a back-to-back start bit is not missed
        if (smp3_hit_c) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          frame_err_d  = ~maj_c;
          parity_err_d = perr_q;
          if (maj_c && !perr_q) begin
            rx_data_d     = 8'(shreg_q);
            rx_valid_d    = 1'b1;
            overrun_err_d = rx_valid_q & ~rx_ready;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: a no-parity and an even-parity receiver driven
// from bench-built serial frames at a scaled clock so every baud rate fits the run.
module tb_uart_rx_param;

  localparam int unsigned CLK_HZ = 2_304_000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       line0, line1;
  logic       rx_ready;
  logic [2:0] baud_set;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1;
  logic       parity_err0, parity_err1;
  logic       frame_err0, frame_err1;
  logic       overrun_err0, overrun_err1;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .DATA_BITS(8), .PARITY(0)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(line0), .baud_set(baud_set),
    .rx_ready(rx_ready), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .parity_err(parity_err0), .frame_err(frame_err0), .overrun_err(overrun_err0)
  );

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .DATA_BITS(8), .PARITY(2)) dut_par (
    .clk(clk), .reset_n(reset_n), .uart_rx(line1), .baud_set(baud_set),
    .rx_ready(rx_ready), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .parity_err(parity_err1), .frame_err(frame_err1), .overrun_err(overrun_err1)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  int fe0 = 0, pe0 = 0, ov0 = 0, fe1 = 0, pe1 = 0, ov1 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: count error pulses, pop the scoreboard on each accepted byte
  always @(negedge clk) begin
    if (frame_err0)   fe0++;
    if (parity_err0)  pe0++;
    if (overrun_err0) ov0++;
    if (frame_err1)   fe1++;
    if (parity_err1)  pe1++;
    if (overrun_err1) ov1++;
    if (rx_valid0 && rx_ready) begin
      check("sb0_pending", 32'(sb0.size() != 0), 32'(1));
      if (sb0.size() != 0) check("rx_data0", 32'(rx_data0), 32'(sb0.pop_front()));
    end
    if (rx_valid1 && rx_ready) begin
      check("sb1_pending", 32'(sb1.size() != 0), 32'(1));
      if (sb1.size() != 0) check("rx_data1", 32'(rx_data1), 32'(sb1.pop_front()));
    end
  end

  function automatic int bps_of(input int b);
    case (b)
      0:       return int'(CLK_HZ / 9600);
      1:       return int'(CLK_HZ / 19200);
      2:       return int'(CLK_HZ / 38400);
      3:       return int'(CLK_HZ / 57600);
      default: return int'(CLK_HZ / 115200);
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit sel, input logic v, input int bps);
    if (sel) line1 = v;
    else     line0 = v;
    repeat (bps) @(negedge clk);
  endtask

  // One frame: start, 8 data bits LSB first, optional parity bit, stop bit
  task automatic send(input bit sel, input logic [7:0] data, input bit use_par,
                      input logic par_bit, input logic stop_bit, input int bps);
    drive(sel, 1'b0, bps);
    for (int i = 0; i < 8; i++) drive(sel, data[i], bps);
    if (use_par) drive(sel, par_bit, bps);
    drive(sel, stop_bit, bps);
    if (sel) line1 = 1'b1;
    else     line0 = 1'b1;
  endtask

  initial begin
    logic [7:0] seq [6];
    int lat;
    int s_fe, s_pe, s_ov;
    seq = '{8'h55, 8'hA5, 8'h00, 8'hC3, 8'hF0, 8'h12};

    reset_n  = 1'b0;
    line0    = 1'b1;
    line1    = 1'b1;
    rx_ready = 1'b1;
    baud_set = 3'd4;
    idle(3);
    check("reset_out0", 32'({rx_data0, rx_valid0, parity_err0, frame_err0, overrun_err0}), 32'(0));
    check("reset_out1", 32'({rx_data1, rx_valid1, parity_err1, frame_err1, overrun_err1}), 32'(0));
    reset_n = 1'b1;
    idle(5);

    // 0x55 at the fastest rate, with arrival latency window
    s_fe = fe0; s_pe = pe0; s_ov = ov0;
    sb0.push_back(8'h55);
    lat = 0;
    fork
      send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, bps_of(4));
      begin
        while (!rx_valid0 && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("latency_0x55", 32'(lat >= 194 && lat <= 198), 32'(1));
    idle(20);
    check("errs_0x55", 32'((fe0 - s_fe) + (pe0 - s_pe) + (ov0 - s_ov)), 32'(0));
    check("drain_0x55", 32'(sb0.size()), 32'(0));

    // Back-to-back sequence at every baud rate
    for (int b = 0; b < 5; b++) begin
      baud_set = 3'(b);
      s_fe = fe0; s_pe = pe0; s_ov = ov0;
      for (int k = 0; k < 6; k++) begin
        sb0.push_back(seq[k]);
        send(1'b0, seq[k], 1'b0, 1'b0, 1'b1, bps_of(b));
      end
      idle(2 * bps_of(b));
      check($sformatf("drain_rate%0d", b), 32'(sb0.size()), 32'(0));
      check($sformatf("errs_rate%0d", b), 32'((fe0 - s_fe) + (pe0 - s_pe) + (ov0 - s_ov)), 32'(0));
    end

    // Even parity: 0xA5 has four ones, so the correct parity bit is 0
    baud_set = 3'd4;
    s_fe = fe1; s_pe = pe1;
    send(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, bps_of(4));
    idle(20);
    check("par_bad_pe", 32'(pe1 - s_pe), 32'(1));
    check("par_bad_fe", 32'(fe1 - s_fe), 32'(0));
    check("par_bad_valid", 32'(rx_valid1), 32'(0));
    sb1.push_back(8'hA5);
    send(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, bps_of(4));
    idle(20);
    check("par_good_pe", 32'(pe1 - s_pe), 32'(1));
    check("par_good_drain", 32'(sb1.size()), 32'(0));
    send(1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, bps_of(4));
    idle(40);
    check("par_stop_pe", 32'(pe1 - s_pe), 32'(2));
    check("par_stop_fe", 32'(fe1 - s_fe), 32'(1));
    check("par_stop_data", 32'(rx_data1), 32'(8'hA5));

    // Short low glitch on an idle line is a false start
    s_fe = fe0; s_pe = pe0; s_ov = ov0;
    line0 = 1'b0;
    idle(3);
    line0 = 1'b1;
    idle(60);
    check("glitch_errs", 32'((fe0 - s_fe) + (pe0 - s_pe) + (ov0 - s_ov)), 32'(0));
    check("glitch_valid", 32'(rx_valid0), 32'(0));
    sb0.push_back(8'h5A);
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, bps_of(4));
    idle(20);
    check("glitch_after_drain", 32'(sb0.size()), 32'(0));

    // Stop bit forced low on 0x3C
    s_fe = fe0; s_pe = pe0; s_ov = ov0;
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, bps_of(4));
    idle(40);
    check("ferr_fe", 32'(fe0 - s_fe), 32'(1));
    check("ferr_others", 32'((pe0 - s_pe) + (ov0 - s_ov)), 32'(0));
    check("ferr_data_kept", 32'(rx_data0), 32'(8'h5A));

    // baud_set changed mid-frame must not disturb the frame in flight
    baud_set = 3'd2;
    sb0.push_back(8'hB7);
    fork
      send(1'b0, 8'hB7, 1'b0, 1'b0, 1'b1, bps_of(2));
      begin
        idle(4 * bps_of(2));
        baud_set = 3'd0;
      end
    join
    baud_set = 3'd4;
    idle(20);
    check("midbaud_drain", 32'(sb0.size()), 32'(0));

    // Overrun: two bytes with no consumer, then drain
    s_ov = ov0;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, bps_of(4));
    check("ovr_first_none", 32'(ov0 - s_ov), 32'(0));
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, bps_of(4));
    idle(20);
    check("ovr_pulse", 32'(ov0 - s_ov), 32'(1));
    check("ovr_data", 32'(rx_data0), 32'(8'h22));
    check("ovr_valid", 32'(rx_valid0), 32'(1));
    sb0.push_back(8'h22);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_clear", 32'(rx_valid0), 32'(0));
    check("ovr_drain", 32'(sb0.size()), 32'(0));

    // Reset during data bit 4 aborts the frame and clears held output
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    send(1'b0, 8'h44, 1'b0, 1'b0, 1'b1, bps_of(4));
    idle(10);
    check("rst_pre_valid", 32'(rx_valid0), 32'(1));
    fork
      send(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, bps_of(4));
      begin
        idle(5 * bps_of(4) + bps_of(4) / 2);
        reset_n = 1'b0;
        #1;
        check("rst_mid_out0", 32'({rx_data0, rx_valid0, parity_err0, frame_err0, overrun_err0}), 32'(0));
      end
    join
    check("rst_hold_out0", 32'({rx_data0, rx_valid0, parity_err0, frame_err0, overrun_err0}), 32'(0));
    rx_ready = 1'b1;
    idle(5);
    reset_n = 1'b1;
    idle(5);
    sb0.push_back(8'h9A);
    send(1'b0, 8'h9A, 1'b0, 1'b0, 1'b1, bps_of(4));
    idle(20);
    check("rst_after_data", 32'(rx_data0), 32'(8'h9A));
    check("rst_after_drain", 32'(sb0.size()), 32'(0));

    check("final_sb0", 32'(sb0.size()), 32'(0));
    check("final_sb1", 32'(sb1.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Port clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port uart_rx  input  1  asynchronous serial line; idle high; LSB first.
REQ-007 Port baud_set  input  3  baud select: 0 9600, 1 19200, 2 38400, 3 57600, 4-7 115200.
REQ-008 Port rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-009 Port rx_data  output  8  received data, right-aligned; bits above DATA_BITS are 0.
REQ-010 Port rx_valid  output  1  level; rx_data holds an unconsumed byte.
REQ-011 Port parity_err  output  1  one-cycle pulse; parity check failed.
REQ-012 Port frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-013 Port overrun_err  output  1  one-cycle pulse; new byte overwrote an unconsumed byte.

Function
REQ-014 uart_rx SHALL pass through a 2-FF synchronizer plus one history FF; start edge = synced 0 with history 1.
REQ-015 Bit period BPS SHALL be CLK_FREQ/baud, integer-truncated (50 MHz: 5208, 2604, 1302, 868, 434 clocks).
REQ-016 baud_set SHALL be latched on start-edge detection; changes mid-frame have no effect until the next frame.
REQ-017 A per-bit counter SHALL count 0..BPS-1, starting at 0 in the cycle after edge detection and wrapping per bit.
REQ-018 Each bit SHALL be sampled at counts BPS/2-BPS/8, BPS/2 and BPS/2+BPS/8; the bit value is the majority of the 3 samples.
REQ-019 FSM states SHALL be IDLE, START, DATA, PAR, STOP; PAR is skipped when PARITY=0.
REQ-020 IDLE->START on start edge; START->IDLE if the start majority is 1 (false start, no outputs); otherwise START->DATA at bit end.
REQ-021 DATA SHALL shift DATA_BITS bits LSB first, then go to PAR or STOP at bit end.
REQ-022 PAR SHALL compute odd/even parity over the data bits plus the parity bit; a mismatch is latched as a parity error.
REQ-023 STOP SHALL evaluate in the cycle after the third stop sample, then return to IDLE without waiting for the end of the stop bit.
REQ-024 Good frame (stop=1, parity ok): rx_data loads and rx_valid is set in the cycle after the third stop sample.
REQ-025 Stop=0: frame_err pulses; rx_data and rx_valid are unchanged.
REQ-026 Parity fail with stop=1: parity_err pulses; rx_data and rx_valid are unchanged.
REQ-027 Parity fail with stop=0: both parity_err and frame_err pulse.
REQ-028 rx_valid SHALL clear in the cycle after rx_valid&rx_ready, unless a new good byte loads in that same cycle.
REQ-029 Good byte with rx_valid=1 and rx_ready=0: rx_data is overwritten, rx_valid stays 1, overrun_err pulses.
REQ-030 Good byte with rx_valid=1 and rx_ready=1 in the same cycle: the old byte is consumed, the new byte loads, rx_valid stays 1, no overrun.
REQ-031 Back-to-back frames (next start bit directly after the stop bit) SHALL be received without loss.

Reset
REQ-032 On reset_n=0, asynchronously: FSM to IDLE; counters to 0; synchronizer/history FFs to 1; rx_data=0; rx_valid, parity_err, frame_err, overrun_err=0.
REQ-033 Reset mid-frame SHALL abort the frame with no outputs; the first frame after release is received normally.

Verification
REQ-034 50 MHz clk, baud_set=4, 8N1, rx_ready=1, byte 0x55 -> rx_valid=1 with rx_data=0x55 about 9.6 BPS (~4170 clk) after the start edge; no error pulses.
REQ-035 baud_set=0..4, sequence 0x55,0xA5,0x00,0xC3,0xF0,0x12 back-to-back -> every byte received in order at every rate.
REQ-036 PARITY=2, byte 0xA5 sent with parity bit 1 -> parity_err pulse, no rx_valid; with parity bit 0 -> rx_data=0xA5.
REQ-037 100 ns low glitch on idle line -> no outputs, FSM returns to IDLE; stop bit forced low on 0x3C -> frame_err pulse only.
REQ-038 rx_ready=0, bytes 0x11 then 0x22 -> overrun_err pulse at the second byte, rx_data=0x22, rx_valid=1; raising rx_ready clears rx_valid after 1 cycle.
REQ-039 reset_n low during data bit 4, released, then 0x9A sent -> all outputs 0 during reset; rx_data=0x9A after the frame.
